// File: rtl/cache_dre_pkg.sv
// Shared types and constants for the dre maintenance controller.
package cache_dre_pkg;

   // Maintenance command encoding as seen on cmd_op.
   typedef enum logic [1:0] {
      DRE_CLEAR     = 2'd0,
      DRE_FILL      = 2'd1,
      DRE_FLUSH_ALL = 2'd2,
      DRE_CHECK     = 2'd3
   } dreOp_t;

   // Controller sequencing states.
   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StRun,
      StDrain,
      StDone
   } dreState_t;

   // One bit per byte of a packed word pair.
   localparam logic [7:0] DRE_ALL_READABLE  = 8'hFF;
   localparam logic [7:0] DRE_NONE_READABLE = 8'h00;

endpackage

// File: rtl/cache_dre_addr_gen.sv
// Pair/channel counters for the dre controller: walks one line (P pairs) or, in
// flush mode, every entry of every way, and flags the last operation.
module cache_dre_addr_gen
   import cache_dre_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 9,
   parameter int unsigned LINE_WORDS_LOG2 = 3
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  clear,
   input  logic                                  step,
   input  logic                                  flushMode,
   input  logic [ADDR_WIDTH-LINE_WORDS_LOG2-1:0] line,
   input  logic [1:0]                            lineChannel,
   output logic [ADDR_WIDTH-1:0]                 address,
   output logic [1:0]                            channel,
   output logic                                  lastOp
);

   localparam int unsigned PW = ADDR_WIDTH - 1;
   // Pair bits that belong to one line; zero when a line is a single pair.
   localparam logic [PW-1:0] LineMask = PW'((1 << (LINE_WORDS_LOG2 - 1)) - 1);

   logic [PW-1:0] pair_q;
   logic [1:0]    flushChannel_q;
   logic          pairWrap;
   logic [PW-1:0] linePair;

   assign pairWrap = &pair_q;
   assign linePair = pair_q & LineMask;

   // Pair counter always advances; the flush channel advances on pair wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pair_q         <= '0;
         flushChannel_q <= 2'd0;
      end else if (clear) begin
         pair_q         <= '0;
         flushChannel_q <= 2'd0;
      end else if (step) begin
         pair_q <= pair_q + 1'b1;
         if (flushMode && pairWrap) begin
            flushChannel_q <= flushChannel_q + 2'd1;
         end
      end
   end

   // Address, way and last-op decode for the current operation.
   always_comb begin
      address = '0;
      channel = lineChannel;
      lastOp  = 1'b0;
      if (flushMode) begin
         address = {pair_q, 1'b0};
         channel = flushChannel_q;
         lastOp  = pairWrap && (flushChannel_q == 2'd3);
      end else begin
         address = {line, {LINE_WORDS_LOG2{1'b0}}} | {linePair, 1'b0};
         lastOp  = (linePair == LineMask);
      end
   end

endmodule

// File: rtl/cache_dre_ctrl.sv
// Maintenance sequencer and ri-side arbiter for the cache dre RAM wrapper.
// Waits for the rw pipeline to go idle, takes the RAM mux, runs one RAM op per
// cycle for the command, then hands the RAM back.
module cache_dre_ctrl
   import cache_dre_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 9,
   parameter int unsigned LINE_WORDS_LOG2 = 3,
   parameter bit          INIT_FLUSH      = 1'b1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  cmd_valid,
   output logic                                  cmd_ready,
   input  logic [1:0]                            cmd_op,
   input  logic [1:0]                            cmd_channel,
   input  logic [ADDR_WIDTH-LINE_WORDS_LOG2-1:0] cmd_line,
   output logic                                  done,
   output logic                                  check_ok,
   input  logic                                  rw_busy,
   output logic                                  rw_stall,
   output logic                                  sel,
   output logic [ADDR_WIDTH-1:0]                 ri_readAddress,
   output logic [1:0]                            ri_readChannel,
   input  logic [7:0]                            ri_readData,
   output logic [ADDR_WIDTH-1:0]                 ri_writeAddress,
   output logic [1:0]                            ri_writeChannel,
   output logic                                  ri_writeEnable,
   output logic [7:0]                            ri_writeData
);

   localparam int unsigned LW = ADDR_WIDTH - LINE_WORDS_LOG2;

   dreState_t       state_q, state_d;
   dreOp_t          op_q;
   logic [1:0]      channel_q;
   logic [LW-1:0]   line_q;
   logic            ok_q;
   logic            readPending_q;

   logic                  accept;
   logic [ADDR_WIDTH-1:0] genAddress;
   logic [1:0]            genChannel;
   logic                  lastOp;

   assign accept = (state_q == StIdle) && cmd_valid;

   cache_dre_addr_gen #(
      .ADDR_WIDTH      (ADDR_WIDTH),
      .LINE_WORDS_LOG2 (LINE_WORDS_LOG2)
   ) u_addrGen (
      .clk         (clk),
      .rst         (rst),
      .clear       (accept),
      .step        (state_q == StRun),
      .flushMode   (op_q == DRE_FLUSH_ALL),
      .line        (line_q),
      .lineChannel (channel_q),
      .address     (genAddress),
      .channel     (genChannel),
      .lastOp      (lastOp)
   );

   // State, latched command and CHECK accumulator; reset may start a flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= INIT_FLUSH ? StWait : StIdle;
         op_q          <= INIT_FLUSH ? DRE_FLUSH_ALL : DRE_CLEAR;
         channel_q     <= 2'd0;
         line_q        <= '0;
         ok_q          <= 1'b1;
         readPending_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q      <= dreOp_t'(cmd_op);
            channel_q <= cmd_channel;
            line_q    <= cmd_line;
            ok_q      <= 1'b1;
         end else if (readPending_q) begin
            // Read data lands one cycle after the read was issued.
            ok_q <= ok_q & (ri_readData == DRE_ALL_READABLE);
         end
         readPending_q <= (state_q == StRun) && (op_q == DRE_CHECK);
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d         = state_q;
      cmd_ready       = 1'b0;
      rw_stall        = 1'b1;
      sel             = 1'b0;
      done            = 1'b0;
      check_ok        = 1'b0;
      ri_writeEnable  = 1'b0;
      ri_writeData    = DRE_NONE_READABLE;
      ri_readAddress  = '0;
      ri_writeAddress = '0;
      ri_readChannel  = 2'd0;
      ri_writeChannel = 2'd0;

      if (state_q != StIdle) begin
         ri_readAddress  = genAddress;
         ri_writeAddress = genAddress;
         ri_readChannel  = genChannel;
         ri_writeChannel = genChannel;
      end

      unique case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            rw_stall  = 1'b0;
            if (cmd_valid) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (!rw_busy) begin
               state_d = StRun;
            end
         end
         StRun: begin
            sel = 1'b1;
            if (op_q != DRE_CHECK) begin
               ri_writeEnable = 1'b1;
               ri_writeData   = (op_q == DRE_FILL) ? DRE_ALL_READABLE : DRE_NONE_READABLE;
            end
            if (lastOp) begin
               state_d = (op_q == DRE_CHECK) ? StDrain : StDone;
            end
         end
         StDrain: begin
            // Keep the ri side selected so the last read's forwarding stays valid.
            sel     = 1'b1;
            state_d = StDone;
         end
         StDone: begin
            done     = 1'b1;
            check_ok = (op_q == DRE_CHECK) && ok_q;
            rw_stall = 1'b0;
            state_d  = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule
